// File: rtl/vx_commit_pkg.sv
// Shared types and sizes for the commit/writeback path: unit indices,
// default widths and the per-unit commit record.
package vx_commit_pkg;

    localparam int UNIT_ALU    = 0;
    localparam int UNIT_LD     = 1;
    localparam int UNIT_CSR    = 2;
    localparam int UNIT_FPU    = 3;
    localparam int UNIT_GPU    = 4;
    localparam int NUM_UNITS   = 5;

    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 4;
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int XLEN        = 32;
    localparam int RD_BITS     = 5;
    localparam int CNT_BITS    = $clog2(NUM_UNITS + 1);
    localparam int UNIT_BITS   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef struct packed {
        logic [NW_BITS-1:0]          wid;
        logic [NUM_THREADS-1:0]      tmask;
        logic [RD_BITS-1:0]          rd;
        logic                        wb;
        logic                        eop;
        logic [NUM_THREADS*XLEN-1:0] data;
    } commit_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap-around,
// grants at most one requester per cycle and advances past the winner.
module vx_rr_arbiter #(
    parameter int NUM_REQS = 5,
    parameter int IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests_i,
    input  logic                enable_i,
    output logic [NUM_REQS-1:0] grant_o,
    output logic [IDX_BITS-1:0] grant_idx_o,
    output logic                grant_valid_o
);

    logic [IDX_BITS-1:0] ptr_q;
    logic [IDX_BITS-1:0] ptr_d;
    logic [IDX_BITS:0]   sum;
    logic [IDX_BITS-1:0] cand;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        sum           = '0;
        cand          = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            sum = {1'b0, ptr_q} + (IDX_BITS+1)'(k);
            if (sum >= (IDX_BITS+1)'(NUM_REQS)) begin
                sum = sum - (IDX_BITS+1)'(NUM_REQS);
            end
            cand = sum[IDX_BITS-1:0];
            if (enable_i && !grant_valid_o && requests_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                grant_valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid_o) begin
            if (grant_idx_o == IDX_BITS'(NUM_REQS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vx_commit_wb_arb.sv
// Commit writeback arbiter: merges the per-unit commit streams onto one
// registered register-file write port and counts retired instructions.
module vx_commit_wb_arb #(
    parameter int NUM_UNITS   = vx_commit_pkg::NUM_UNITS,
    parameter int NUM_THREADS = vx_commit_pkg::NUM_THREADS,
    parameter int NUM_WARPS   = vx_commit_pkg::NUM_WARPS,
    parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int XLEN        = vx_commit_pkg::XLEN,
    parameter int RD_BITS     = vx_commit_pkg::RD_BITS,
    parameter int CNT_BITS    = $clog2(NUM_UNITS + 1),
    parameter int UNIT_BITS   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_UNITS-1:0]                  in_valid,
    input  logic [NUM_UNITS*NW_BITS-1:0]          in_wid,
    input  logic [NUM_UNITS*NUM_THREADS-1:0]      in_tmask,
    input  logic [NUM_UNITS*RD_BITS-1:0]          in_rd,
    input  logic [NUM_UNITS-1:0]                  in_wb,
    input  logic [NUM_UNITS-1:0]                  in_eop,
    input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data,
    output logic [NUM_UNITS-1:0]                  in_ready,
    output logic                                  wb_valid,
    output logic [NW_BITS-1:0]                    wb_wid,
    output logic [RD_BITS-1:0]                    wb_rd,
    output logic [NUM_THREADS-1:0]                wb_tmask,
    output logic [NUM_THREADS*XLEN-1:0]           wb_data,
    output logic                                  wb_eop,
    output logic [UNIT_BITS-1:0]                  wb_unit,
    output logic                                  cmt_valid,
    output logic [CNT_BITS-1:0]                   cmt_count
);
    import vx_commit_pkg::*;

    localparam int DW = NUM_THREADS * XLEN;

    commit_t                units [NUM_UNITS];
    commit_t                sel;
    logic [NUM_UNITS-1:0]   wb_req;
    logic [NUM_UNITS-1:0]   nwb;
    logic [NUM_UNITS-1:0]   grant;
    logic [NUM_UNITS-1:0]   fire;
    logic [UNIT_BITS-1:0]   grant_idx;
    logic                   grant_valid;
    logic [CNT_BITS-1:0]    cmt_count_d;

    logic                   wb_valid_q;
    logic [NW_BITS-1:0]     wb_wid_q;
    logic [RD_BITS-1:0]     wb_rd_q;
    logic [NUM_THREADS-1:0] wb_tmask_q;
    logic [DW-1:0]          wb_data_q;
    logic                   wb_eop_q;
    logic [UNIT_BITS-1:0]   wb_unit_q;
    logic                   cmt_valid_q;
    logic [CNT_BITS-1:0]    cmt_count_q;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            units[i].wid   = in_wid[i*NW_BITS +: NW_BITS];
            units[i].tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
            units[i].rd    = in_rd[i*RD_BITS +: RD_BITS];
            units[i].wb    = in_wb[i];
            units[i].eop   = in_eop[i];
            units[i].data  = in_data[i*DW +: DW];
        end
    end

    always_comb begin
        wb_req = '0;
        nwb    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            wb_req[i] = in_valid[i] & units[i].wb;
            nwb[i]    = in_valid[i] & ~units[i].wb;
        end
    end

    // Enable is tied to reset so nothing is granted while reset is asserted.
    vx_rr_arbiter #(
        .NUM_REQS (NUM_UNITS),
        .IDX_BITS (UNIT_BITS)
    ) u_arb (
        .clk           (clk),
        .reset         (reset),
        .requests_i    (wb_req),
        .enable_i      (reset),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign in_ready = {NUM_UNITS{reset}} & (nwb | grant);
    assign fire     = in_valid & in_ready;
    assign sel      = units[grant_idx];

    always_comb begin
        cmt_count_d = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (fire[i] && units[i].eop) begin
                cmt_count_d = cmt_count_d + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_valid_q  <= 1'b0;
            wb_wid_q    <= '0;
            wb_rd_q     <= '0;
            wb_tmask_q  <= '0;
            wb_data_q   <= '0;
            wb_eop_q    <= 1'b0;
            wb_unit_q   <= '0;
            cmt_valid_q <= 1'b0;
            cmt_count_q <= '0;
        end else begin
            wb_valid_q  <= grant_valid;
            cmt_count_q <= cmt_count_d;
            cmt_valid_q <= (cmt_count_d != '0);
            // Payload holds its last value when no writeback is granted.
            if (grant_valid) begin
                wb_wid_q   <= sel.wid;
                wb_rd_q    <= sel.rd;
                wb_tmask_q <= sel.tmask;
                wb_data_q  <= sel.data;
                wb_eop_q   <= sel.eop;
                wb_unit_q  <= grant_idx;
            end
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_wid    = wb_wid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_tmask  = wb_tmask_q;
    assign wb_data   = wb_data_q;
    assign wb_eop    = wb_eop_q;
    assign wb_unit   = wb_unit_q;
    assign cmt_valid = cmt_valid_q;
    assign cmt_count = cmt_count_q;

endmodule
